// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem read handshake, small fetch queue.
// Optional IF_PERF_CNT_EN adds saturating fetched/stall performance counters.
module etapa_fetch #(
  parameter int                 PC_W      = 8,
  parameter int                 INSTR_W   = 14,
  parameter int                 QDEPTH    = 2,
  parameter logic [PC_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);
  localparam int AW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  typedef enum logic {S_REQ, S_WAIT} state_t;

  state_t          state, state_nx;
  logic [PC_W-1:0] fetch_pc, fetch_pc_nx, req_pc, req_pc_nx;
  logic            discard, discard_nx;
  logic            accept, push, pop;
  entry_t          q [QDEPTH];
  logic [AW-1:0]   head, tail;
  logic [CW-1:0]   count;

  assign imem_addr       = fetch_pc;
  assign inst_valid      = (count != '0);
  assign instruction_out = inst_valid ? q[head].instr : NOP_INSTR;
  assign pc_out          = inst_valid ? q[head].pc : '0;
  assign pop             = inst_valid & ~stall_in & ~redirect_valid;

  always_comb begin
    imem_req    = rst_n && (state == S_REQ) && (count < CW'(QDEPTH));
    accept      = imem_req & imem_ready;
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    req_pc_nx   = req_pc;
    discard_nx  = discard;
    push        = 1'b0;
    case (state)
      S_REQ: if (accept) begin
        state_nx    = S_WAIT;
        req_pc_nx   = fetch_pc;
        fetch_pc_nx = fetch_pc + PC_W'(1);
      end
      S_WAIT: if (imem_rvalid) begin
        push       = ~discard;
        discard_nx = 1'b0;
        state_nx   = S_REQ;
      end
      default: state_nx = S_REQ;
    endcase
    // A redirect poisons whatever read is (or is about to be) in flight.
    if (redirect_valid) begin
      fetch_pc_nx = redirect_pc;
      push        = 1'b0;
      if (accept || (state == S_WAIT && !imem_rvalid)) discard_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      discard  <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_pc   <= req_pc_nx;
      discard  <= discard_nx;
      if (redirect_valid) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (!push && pop) count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{instr: imem_rdata, pc: req_pc};
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (inst_valid && stall_in && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: cycle vectors, directed redirect/reset cases, random run
// against an instruction-stream model (consecutive pcs, restarted by redirect/reset).
module tb_etapa_fetch;
  logic        clk = 1'b0;
  logic        rst_n, imem_req, imem_ready, imem_rvalid, stall_in, redirect_valid, inst_valid;
  logic [7:0]  imem_addr, redirect_pc, pc_out;
  logic [13:0] imem_rdata, instruction_out;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall;
`endif

  etapa_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall_in(stall_in), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instruction_out(instruction_out), .pc_out(pc_out), .inst_valid(inst_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  bit          pend = 0, rand_lat = 0, redir_q = 0, consumed = 0;
  logic [7:0]  pend_addr = '0, exp_pc = '0;
  int          pend_cnt = 0, lat = 1, gap = 0, max_gap = 0;
  int unsigned model_stall = 0;

  function automatic logic [13:0] memf(logic [7:0] a);
    return 14'h100 + {6'b0, a};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: memory accept, stream-model update, then advance to next negedge.
  task automatic step();
    if (imem_req && imem_ready) begin
      chk("one_outstanding", {31'b0, pend}, 32'd0);
      pend      = 1;
      pend_addr = imem_addr;
      pend_cnt  = rand_lat ? int'($urandom_range(1, 3)) : lat;
    end
    consumed = 0;
    if (!rst_n) begin
      exp_pc      = 8'h00;
      model_stall = 0;
    end else if (redirect_valid) begin
      exp_pc = redirect_pc;
    end else if (inst_valid && !stall_in) begin
      chk("stream", {10'b0, instruction_out, pc_out}, {10'b0, memf(exp_pc), exp_pc});
      exp_pc++;
      consumed = 1;
    end
    if (rst_n && inst_valid && stall_in) model_stall++;
    redir_q = rst_n && redirect_valid;
    @(negedge clk);
    imem_rvalid = 0;
    imem_rdata  = 14'(($urandom));
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        imem_rvalid = 1;
        imem_rdata  = memf(pend_addr);
        pend        = 0;
      end
    end
    if (redir_q) chk("redirect_flush", {31'b0, inst_valid}, 32'd0);
  endtask

  task automatic wait_valid(string name, logic [7:0] exp);
    for (int i = 0; i < 40; i++) begin
      if (inst_valid) begin
        chk(name, {24'b0, pc_out}, {24'b0, exp});
        return;
      end
      step();
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  typedef struct {
    bit         rst, stall, rdy;
    bit         req;
    logic [7:0] addr;
    bit         vld;
    logic [7:0] pc;
    logic [13:0] ins;
  } vec_t;
  vec_t tbl [15];

  initial begin
    rst_n = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = '0;
    stall_in = 0; redirect_valid = 0; redirect_pc = '0;
    tbl[0]  = '{0,0,1, 0,8'h00,0,8'h00,14'h000};
    tbl[1]  = '{1,0,1, 1,8'h00,0,8'h00,14'h000};
    tbl[2]  = '{1,0,1, 0,8'h01,0,8'h00,14'h000};
    tbl[3]  = '{1,0,1, 1,8'h01,1,8'h00,14'h100};
    tbl[4]  = '{1,0,1, 0,8'h02,0,8'h00,14'h000};
    tbl[5]  = '{1,1,1, 1,8'h02,1,8'h01,14'h101};
    tbl[6]  = '{1,1,1, 0,8'h03,1,8'h01,14'h101};
    tbl[7]  = '{1,1,1, 0,8'h03,1,8'h01,14'h101};
    tbl[8]  = '{1,1,1, 0,8'h03,1,8'h01,14'h101};
    tbl[9]  = '{1,1,1, 0,8'h03,1,8'h01,14'h101};
    tbl[10] = '{1,1,1, 0,8'h03,1,8'h01,14'h101};
    tbl[11] = '{1,0,1, 0,8'h03,1,8'h01,14'h101};
    tbl[12] = '{1,0,1, 1,8'h03,1,8'h02,14'h102};
    tbl[13] = '{1,0,1, 0,8'h04,0,8'h00,14'h000};
    tbl[14] = '{1,0,1, 1,8'h04,1,8'h03,14'h103};
    repeat (2) @(negedge clk);

    // reset state, streaming with 1-cycle memory, stall backpressure
    for (int i = 0; i < 15; i++) begin
      rst_n = tbl[i].rst; stall_in = tbl[i].stall; imem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d", i),
          {imem_req, imem_addr, inst_valid, pc_out, instruction_out},
          {tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc, tbl[i].ins});
      step();
    end
    stall_in = 0;

`ifdef IF_PERF_CNT_EN
    chk("perf_stall_vec", perf_stall, 32'd6);
`endif

    // redirect while waiting on an outstanding read
    lat = 2;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 1); i++) step();
    redirect_valid = 1; redirect_pc = 8'h40;
    step();
    redirect_valid = 0;
    wait_valid("redir_wait_pc", 8'h40);

    // redirect in the same cycle the request is accepted
    lat = 1;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    redirect_valid = 1; redirect_pc = 8'h20;
    step();
    redirect_valid = 0;
    for (int i = 0; i < 20 && !imem_req; i++) step();
    chk("redir_accept_addr", {24'b0, imem_addr}, 32'h20);
    wait_valid("redir_accept_pc", 8'h20);

    // reset mid-wait, stray late rvalid afterwards
    lat = 3;
    for (int i = 0; i < 20 && !(pend && pend_cnt == 2); i++) step();
    imem_ready = 0; rst_n = 0;
    #1;
    chk("rst_mid_outputs", {imem_req, imem_addr, inst_valid, pc_out, instruction_out}, 32'd0);
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_stray_ignored", {31'b0, inst_valid}, 32'd0);
      step();
    end
    chk("rst_first_req", {23'b0, imem_req, imem_addr}, {23'b0, 1'b1, 8'h00});
    imem_ready = 1; lat = 1;
    wait_valid("rst_first_pc", 8'h00);

    // PC wrap from 0xFE after a fresh reset
    imem_ready = 0; rst_n = 0;
    step();
    rst_n = 1;
`ifdef IF_PERF_CNT_EN
    chk("perf_reset", perf_fetched | perf_stall, 32'd0);
`endif
    redirect_valid = 1; redirect_pc = 8'hFE;
    step();
    redirect_valid = 0; imem_ready = 1;
    begin
      logic [7:0] wexp [3];
      int k;
      wexp[0] = 8'hFE; wexp[1] = 8'hFF; wexp[2] = 8'h00; k = 0;
      for (int i = 0; i < 40 && k < 3; i++) begin
        if (inst_valid) begin
          chk($sformatf("wrap%0d", k), {10'b0, instruction_out, pc_out}, {10'b0, memf(wexp[k]), wexp[k]});
          k++;
`ifdef IF_PERF_CNT_EN
          if (k == 3) chk("perf_fetched3", perf_fetched, 32'd3);
`endif
        end
        step();
      end
      chk("wrap_count", k, 32'd3);
    end

    // random traffic against the stream model
    rand_lat = 1;
    for (int i = 0; i < 3000; i++) begin
      stall_in       = ($urandom % 10) < 3;
      imem_ready     = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = 8'($urandom);
      step();
      if (consumed || redir_q) gap = 0;
      else if (!stall_in) gap++;
      if (gap > max_gap) max_gap = gap;
    end
    redirect_valid = 0; stall_in = 0;
    chk("liveness", {31'b0, max_gap > 40}, 32'd0);
`ifdef IF_PERF_CNT_EN
    chk("perf_stall_rand", perf_stall, model_stall);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
